// File: rtl/fc_pkg.sv
// Shared types and helpers for the VC scheduler: FSM state encoding, default widths,
// and the round-robin next-grant search.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fc_state_e;

  localparam int NUM_VC_DEF = 8;
  localparam int VC_W_DEF   = 3;
  localparam int DATA_W_DEF = 10;
  localparam int MAX_VC     = 32;

  // First set bit of req after position last, wrapping modulo n; returns last if none.
  function automatic int unsigned rr_next_grant(input logic [MAX_VC-1:0] req,
                                                input int unsigned       last,
                                                input int unsigned       n);
    int unsigned pick;
    logic        found;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_VC; k++) begin
      if (!found && (k <= n) && req[(last + k) % n]) begin
        pick  = (last + k) % n;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_grant_pick.sv
// Combinational masked priority encoder: keeps the current VC while a burst may
// continue, otherwise picks the next requester after last_grant.
module rr_grant_pick
  import fc_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_W   = VC_W_DEF
) (
  input  logic [NUM_VC-1:0] req_i,
  input  logic [VC_W-1:0]   last_grant_i,
  input  logic              hold_en_i,
  output logic [VC_W-1:0]   grant_o,
  output logic              valid_o
);

  logic [MAX_VC-1:0] req_ext;

  assign req_ext = MAX_VC'(req_i);
  assign valid_o = |req_i;

  always_comb begin
    grant_o = last_grant_i;
    if (!(hold_en_i && req_i[last_grant_i])) begin
      grant_o = VC_W'(rr_next_grant(req_ext, 32'(last_grant_i), NUM_VC));
    end
  end

endmodule

// File: rtl/vc_rr_scheduler.sv
// Round-robin drain of NUM_VC show-ahead VC FIFOs into one downstream FIFO, with
// per-VC burst limit, same-cycle backpressure/disable gating and a registered push.
module vc_rr_scheduler
  import fc_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_W   = VC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_VC-1:0]        fifo_empty,
  input  logic [NUM_VC*DATA_W-1:0] fifo_data,
  input  logic                     out_almost_full,
  output logic [NUM_VC-1:0]        fifo_pop,
  output logic                     out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic [VC_W-1:0]          out_vc,
  output logic                     busy
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  fc_state_e         state_q, state_d;
  logic [VC_W-1:0]   last_q, last_d;
  logic [3:0]        burst_q, burst_d;
  logic [NUM_VC-1:0] req;
  logic [VC_W-1:0]   grant;
  logic              grant_valid;
  logic              hold_en;
  logic              pop_ok;
  logic              out_push_q;
  logic [DATA_W-1:0] out_data_q;
  logic [VC_W-1:0]   out_vc_q;
  logic              busy_q;

  assign req     = ~fifo_empty;
  assign hold_en = (burst_q != 4'd0) && (burst_q < BURST_L);

  rr_grant_pick #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .hold_en_i    (hold_en),
    .grant_o      (grant),
    .valid_o      (grant_valid)
  );

  // Reset gates the pop so no VC is drained while the block is held in reset.
  assign pop_ok = reset && enable && !out_almost_full && grant_valid;

  always_comb begin
    fifo_pop = '0;
    if (pop_ok) begin
      fifo_pop[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (out_almost_full) begin
      state_d = HOLD;
    end else begin
      state_d = RUN;
    end
    if (pop_ok) begin
      last_d  = grant;
      burst_d = ((grant == last_q) && (burst_q < BURST_L)) ? burst_q + 4'd1 : 4'd1;
    end else if (!enable) begin
      burst_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= VC_W'(NUM_VC - 1);
      burst_q <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      busy_q  <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_push_q <= 1'b0;
      out_data_q <= '0;
      out_vc_q   <= '0;
    end else begin
      out_push_q <= pop_ok;
      if (pop_ok) begin
        out_data_q <= fifo_data[grant*DATA_W +: DATA_W];
        out_vc_q   <= grant;
      end
    end
  end

  assign out_push = out_push_q;
  assign out_data = out_data_q;
  assign out_vc   = out_vc_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// Directed bench for vc_rr_scheduler: a BURST=4 and a BURST=1 instance share stimulus.
module tb_vc_rr_scheduler;
  import fc_pkg::*;

  localparam int NUM_VC = 8;
  localparam int VC_W   = 3;
  localparam int DATA_W = 10;

  logic                     clk;
  logic                     reset;
  logic                     enable;
  logic [NUM_VC-1:0]        fifo_empty;
  logic [NUM_VC*DATA_W-1:0] fifo_data;
  logic                     out_almost_full;

  logic [NUM_VC-1:0] pop4, pop1;
  logic              push4, push1;
  logic [DATA_W-1:0] data4, data1;
  logic [VC_W-1:0]   vc4, vc1;
  logic              busy4, busy1;

  int checks   = 0;
  int failures = 0;

  vc_rr_scheduler #(.NUM_VC(NUM_VC), .VC_W(VC_W), .DATA_W(DATA_W), .BURST(4)) u_b4 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .out_almost_full(out_almost_full),
    .fifo_pop(pop4), .out_push(push4), .out_data(data4), .out_vc(vc4), .busy(busy4)
  );

  vc_rr_scheduler #(.NUM_VC(NUM_VC), .VC_W(VC_W), .DATA_W(DATA_W), .BURST(1)) u_b1 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .out_almost_full(out_almost_full),
    .fifo_pop(pop1), .out_push(push1), .out_data(data1), .out_vc(vc1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, logging the cycle.
  task automatic step();
    $display("t=%0t en=%b afull=%b empty=%b pop4=%b push4=%b vc4=%0d pop1=%b push1=%b vc1=%0d",
             $time, enable, out_almost_full, fifo_empty, pop4, push4, vc4, pop1, push1, vc1);
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    out_almost_full = 1'b0;
    mid();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] onehot(input int g);
    return 32'(1) << g;
  endfunction

  function automatic logic [31:0] head(input int g);
    return 32'(10'h3A0 + g);
  endfunction

  int seq_fair [8]  = '{0, 3, 5, 7, 0, 3, 5, 7};
  int seq_burst[10] = '{2, 2, 2, 2, 6, 6, 6, 6, 2, 2};

  initial begin
    for (int i = 0; i < NUM_VC; i++) fifo_data[i*DATA_W +: DATA_W] = 10'(10'h3A0 + i);
    reset = 1'b0;
    enable = 1'b1;
    out_almost_full = 1'b0;
    fifo_empty = 8'h00;
    #1;

    // Reset held with all VCs full and enable high: nothing may pop or push.
    for (int c = 0; c < 2; c++) begin
      mid();
      check("rst_pop4", 32'(pop4), 32'd0);
      check("rst_pop1", 32'(pop1), 32'd0);
      check("rst_push", 32'(push4), 32'd0);
      check("rst_vc", 32'(vc4), 32'd0);
      check("rst_busy", 32'(busy4), 32'd0);
      step();
    end
    reset = 1'b1;
    enable = 1'b0;
    mid();
    check("rel_pop", 32'(pop4), 32'd0);
    check("rel_push", 32'(push4), 32'd0);
    check("rel_busy", 32'(busy4), 32'd0);
    check("rel_last", 32'(u_b4.last_q), 32'd7);
    step();

    // Fairness on the BURST=1 instance: VCs 0,3,5,7 non-empty.
    enable = 1'b1;
    fifo_empty = 8'b0101_0110;
    for (int k = 0; k < 8; k++) begin
      mid();
      check("fair_pop", 32'(pop1), onehot(seq_fair[k]));
      check("fair_busy", 32'(busy1), 32'(k > 0));
      if (k > 0) begin
        check("fair_push", 32'(push1), 32'd1);
        check("fair_vc", 32'(vc1), 32'(seq_fair[k-1]));
        check("fair_data", 32'(data1), head(seq_fair[k-1]));
      end else begin
        check("fair_push0", 32'(push1), 32'd0);
      end
      step();
    end

    // Bursts of 4 between VC2 and VC6, then VC2 alone.
    do_reset();
    enable = 1'b1;
    fifo_empty = 8'b1011_1011;
    for (int k = 0; k < 10; k++) begin
      mid();
      check("burst_pop", 32'(pop4), onehot(seq_burst[k]));
      if (k > 0) check("burst_vc", 32'(vc4), 32'(seq_burst[k-1]));
      step();
    end
    fifo_empty = 8'b1111_1011;
    for (int k = 0; k < 6; k++) begin
      mid();
      check("solo_pop", 32'(pop4), onehot(2));
      check("solo_vc", 32'(vc4), 32'd2);
      check("solo_push", 32'(push4), 32'd1);
      step();
    end

    // Backpressure at burst_cnt=2 of VC3 (VC6 also waiting).
    do_reset();
    enable = 1'b1;
    fifo_empty = 8'b1011_0111;
    for (int k = 0; k < 2; k++) begin
      mid();
      check("bp_pre_pop", 32'(pop4), onehot(3));
      step();
    end
    check("bp_burst2", 32'(u_b4.burst_q), 32'd2);
    out_almost_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("bp_pop", 32'(pop4), 32'd0);
      check("bp_push", 32'(push4), 32'(k == 0));
      if (k > 0) begin
        check("bp_state", 32'(u_b4.state_q), 32'(HOLD));
        check("bp_busy", 32'(busy4), 32'd0);
      end
      step();
    end
    out_almost_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("bp_rel_pop", 32'(pop4), onehot(k < 2 ? 3 : 6));
      step();
    end

    // All empty: no pops, last_grant held at 6; then VC5 for exactly one cycle.
    fifo_empty = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("empty_pop", 32'(pop4), 32'd0);
      check("empty_last", 32'(u_b4.last_q), 32'd6);
      step();
    end
    fifo_empty = 8'b1101_1111;
    mid();
    check("vc5_pop", 32'(pop4), onehot(5));
    step();
    fifo_empty = 8'hFF;
    mid();
    check("vc5_after_pop", 32'(pop4), 32'd0);
    check("vc5_push", 32'(push4), 32'd1);
    check("vc5_vc", 32'(vc4), 32'd5);
    check("vc5_data", 32'(data4), head(5));
    step();
    mid();
    check("vc5_push_off", 32'(push4), 32'd0);
    check("vc5_data_hold", 32'(data4), head(5));
    step();

    // Disable mid-burst on VC1 (VC4 also waiting), re-enable, then reset with push high.
    fifo_empty = 8'b1110_1101;
    for (int k = 0; k < 2; k++) begin
      mid();
      check("dis_pre_pop", 32'(pop4), onehot(1));
      step();
    end
    enable = 1'b0;
    mid();
    check("dis_pop", 32'(pop4), 32'd0);
    check("dis_last_push", 32'(push4), 32'd1);
    check("dis_last_vc", 32'(vc4), 32'd1);
    step();
    mid();
    check("dis_push_off", 32'(push4), 32'd0);
    check("dis_burst", 32'(u_b4.burst_q), 32'd0);
    check("dis_busy", 32'(busy4), 32'd0);
    step();
    enable = 1'b1;
    mid();
    check("reen_pop", 32'(pop4), onehot(4));
    step();
    mid();
    check("reen_push", 32'(push4), 32'd1);
    check("reen_vc", 32'(vc4), 32'd4);
    reset = 1'b0;
    #1;
    check("async_push", 32'(push4), 32'd0);
    check("async_pop", 32'(pop4), 32'd0);
    check("async_busy", 32'(busy4), 32'd0);
    step();
    reset = 1'b1;
    enable = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vc_rr_scheduler.md
Name: vc_rr_scheduler

Overview:
- Round-robin scheduler that drains eight show-ahead virtual-channel FIFOs into one shared downstream FIFO.
- Sits after the flow-control FSM. The FSM's active (non-idle) state drives `enable`.
- Decides which VC is popped each cycle and forwards the selected word with a registered push.
- Honours downstream backpressure and a per-VC burst limit.

Parameters:
- NUM_VC, 8, number of virtual channels; must be a power of two, at least 2.
- VC_W, 3, log2(NUM_VC).
- DATA_W, 10, data word width.
- BURST, 4, maximum consecutive pops granted to one VC before rotating; valid range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = FSM in active state, scheduling allowed.
- fifo_empty  input  NUM_VC  per-VC empty flag; bit i = VC i.
- fifo_data  input  NUM_VC*DATA_W  show-ahead heads; VC i occupies bits [i*DATA_W +: DATA_W].
- out_almost_full  input  1  downstream FIFO almost-full flag.
- fifo_pop  output  NUM_VC  one-hot-or-zero pop strobe; combinational.
- out_push  output  1  registered push to downstream FIFO.
- out_data  output  DATA_W  registered selected word.
- out_vc  output  VC_W  registered index of the VC that produced out_data.
- busy  output  1  registered; 1 while the FSM is in RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_push=0, out_data=0, out_vc=0, busy=0.
  - state=IDLE, last_grant=NUM_VC-1 (so VC0 has first priority), burst_cnt=0.
  - fifo_pop=0 throughout reset.
- States:
  - IDLE: enable=0.
  - RUN: eligible to pop.
  - HOLD: enable=1 but out_almost_full=1.
- Transitions, evaluated every cycle, priority in this order:
  - enable=0 → IDLE.
  - else out_almost_full=1 → HOLD.
  - else → RUN.
- Pop condition: a pop is issued only when all of these hold:
  - enable=1 and out_almost_full=0 in the current cycle (combinational qualification, no extra cycle of latency);
  - at least one fifo_empty bit is 0.
- Grant selection:
  - If burst_cnt>0, burst_cnt<BURST and the VC in last_grant is non-empty, the grant stays on last_grant.
  - Otherwise the grant is the first non-empty VC scanning last_grant+1, last_grant+2, … modulo NUM_VC.
- Never pop an empty VC. fifo_pop has at most one bit set.
- On a pop:
  - last_grant <= grant.
  - burst_cnt <= (grant==last_grant && burst_cnt<BURST) ? burst_cnt+1 : 1.
  - When burst_cnt reaches BURST, the next grant must rotate away if any other VC is non-empty. If no other VC is non-empty, the same VC is granted again and burst_cnt restarts at 1.
- Burst break: if the granted VC goes empty mid-burst, rotate immediately; burst_cnt restarts at 1 for the new VC.
- Datapath, latency 1 cycle from pop to push:
  - out_push <= |fifo_pop.
  - out_data <= selected head.
  - out_vc <= grant.
  - out_data and out_vc hold their values when out_push=0.
- Cycles with no pop (all empty, HOLD or IDLE):
  - last_grant is unchanged.
  - burst_cnt is unchanged in HOLD.
  - burst_cnt is cleared to 0 on entry to IDLE.
- enable falls mid-burst: pops stop in the same cycle. The push already registered from the previous cycle still completes.
- out_almost_full rising: pops stop in the same cycle. The one in-flight push is allowed, because the downstream almost-full threshold must leave ≥1 slot of margin.
- Reset asserted mid-operation: all state clears immediately, including any in-flight push.
- busy is the registered (state==RUN).

Decomposition:
- Shared package `fc_pkg`:
  - state encoding: IDLE=2'd0, RUN=2'd1, HOLD=2'd2;
  - NUM_VC, VC_W and DATA_W defaults;
  - a function computing the round-robin next grant.
- One sub-module, `rr_grant_pick`: combinational masked priority encoder.
  - Inputs: request vector, last_grant, hold_en.
  - Outputs: grant index and valid.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all fifo_empty=0, then release with enable=0 → fifo_pop=0, out_push=0, out_vc=0, busy=0 throughout.
- Fairness, BURST=1:
  - Stimulus: fifo_empty=8'b0101_0110 (VCs 0,3,5,7 non-empty), enable=1, out_almost_full=0.
  - Expected: pop order 0,3,5,7,0,3…; out_push=1 one cycle after each pop; out_vc follows the same sequence.
- Burst, BURST=4:
  - Stimulus: VC2 and VC6 always non-empty.
  - Expected: grants 2,2,2,2,6,6,6,6,2…; if only VC2 is non-empty, VC2 is popped every cycle.
- Backpressure:
  - Stimulus: out_almost_full=1 during a burst of VC3 at burst_cnt=2, held 3 cycles, then dropped.
  - Expected: fifo_pop=0 in those 3 cycles and state=HOLD; on release VC3 gets 2 more pops, then rotation.
- Empty edge:
  - Stimulus: all fifo_empty=1 → no pops, last_grant unchanged. Then set fifo_empty[5]=0 for exactly one cycle.
  - Expected: exactly one pop of VC5; out_data equals VC5's head one cycle later.
- Disable and reset mid-run:
  - Stimulus: drop enable during a burst.
  - Expected: pops stop in the same cycle, the final push still completes, burst_cnt=0. Re-enable → arbitration resumes from last_grant+1. Assert reset with out_push=1 → out_push=0 immediately.
